// File: rtl/cache_pkg.sv
// Shared defaults, derived widths and FSM state encoding for the direct-mapped cache controller.
package cache_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_INDEX_W    = 5;
    localparam int DEF_OFFSET_W   = 5;
    localparam int DEF_DATA_W     = 32;
    localparam int TAG_W          = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;
    localparam int WORDS_PER_LINE = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRMEM,
        RESP
    } state_t;

endpackage

// File: rtl/cache_ctrl_tag_store.sv
// Valid bits and tags for every cache line: combinational lookup, single-line write, whole-array flush.
module tag_store
    import cache_pkg::*;
#(
    parameter int IDX_W = DEF_INDEX_W,
    parameter int TG_W  = TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lk_index,
    input  logic [TG_W-1:0]  lk_tag,
    output logic             hit,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [TG_W-1:0]  wr_tag,
    input  logic             flush
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] valid;
    logic [TG_W-1:0]  tags [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tags are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
        end
    end

    assign hit = valid[lk_index] && (tags[lk_index] == lk_tag);

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-allocate cache controller with 8-word line refill.
// Optional hit/miss statistics outputs are built in when CACHE_STATS_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request; a flush here invalidates every line
// LOOKUP | tag compare on the captured address
// REFILL | fetching words 0..7 of the line from memory
// WRMEM  | write-through of the captured word to memory
// RESP   | completion; cpu_done/cpu_busy update on leaving this state
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_flush,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int TAG_BITS = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORD_W   = OFFSET_W - 2;
    localparam int LINES    = 1 << INDEX_W;
    localparam int DEPTH    = LINES * WORDS_PER_LINE;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

    state_t state, state_nx;

    logic [ADDR_W-1:2]   req_addr;
    logic                req_we;
    logic [DATA_W-1:0]   req_wdata;
    logic [WORD_W-1:0]   word_cnt;
    logic [DATA_W-1:0]   data_mem [DEPTH];

    logic [TAG_BITS-1:0] req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [WORD_W-1:0]   req_word;
    logic                hit;
    logic                accept;
    logic                tag_wr;
    logic                flush_en;
    logic                refill_ack;

    // Byte lanes are irrelevant for a word-wide cache.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_tag    = req_addr[ADDR_W-1 -: TAG_BITS];
    assign req_index  = req_addr[OFFSET_W +: INDEX_W];
    assign req_word   = req_addr[2 +: WORD_W];
    assign refill_ack = (state == REFILL) && mem_ack;

    tag_store #(
        .IDX_W (INDEX_W),
        .TG_W  (TAG_BITS)
    ) u_tag_store (
        .clk      (clk),
        .rst      (rst),
        .lk_index (req_index),
        .lk_tag   (req_tag),
        .hit      (hit),
        .wr_en    (tag_wr),
        .wr_index (req_index),
        .wr_tag   (req_tag),
        .flush    (flush_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        tag_wr    = 1'b0;
        flush_en  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (cpu_flush) begin
                    flush_en = 1'b1;
                end else if (cpu_req) begin
                    accept   = 1'b1;
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_we) begin
                    state_nx = WRMEM;
                end else if (hit) begin
                    state_nx = RESP;
                end else begin
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_index, word_cnt, 2'b00};
                if (mem_ack && (word_cnt == LAST_WORD)) begin
                    tag_wr   = 1'b1;
                    state_nx = RESP;
                end
            end
            WRMEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {req_addr, 2'b00};
                mem_wdata = req_wdata;
                if (mem_ack) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            word_cnt  <= '0;
            cpu_busy  <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_busy <= (state_nx != IDLE);
            cpu_done <= (state == RESP);
            if (accept) begin
                req_addr  <= cpu_addr[ADDR_W-1:2];
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
                word_cnt  <= '0;
            end
            if (refill_ack) begin
                word_cnt <= word_cnt + WORD_W'(1);
            end
            if ((state == RESP) && !req_we) begin
                cpu_rdata <= data_mem[{req_index, req_word}];
            end
        end
    end

    // Refill fills the line word by word; a write hit updates the cached copy as WRMEM is entered.
    always_ff @(posedge clk) begin
        if (refill_ack) begin
            data_mem[{req_index, word_cnt}] <= mem_rdata;
        end else if ((state == LOOKUP) && req_we && hit) begin
            data_mem[{req_index, req_word}] <= req_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 16'd1;
                end
            end else if (miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: vector table of CPU accesses against a word-addressed memory model.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_flush;
    logic        cpu_busy;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_flush (cpu_flush),
        .cpu_busy  (cpu_busy),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: word i initially holds 0xA5000000 | byte address.
    logic [31:0] mem [16384];
    logic [15:0] rd_log [$];
    logic [15:0] wr_log [$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    int          stable_bad = 0;
    logic [15:0] held_addr;
    logic        held_we;
    logic [31:0] held_wd;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 | (i << 2);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (mem_ack || rst || !mem_req) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) begin
                    held_addr = mem_addr;
                    held_we   = mem_we;
                    held_wd   = mem_wdata;
                end else if (mem_addr !== held_addr || mem_we !== held_we || mem_wdata !== held_wd) begin
                    stable_bad++;
                end
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[15:2]] = mem_wdata;
                        wr_log.push_back(mem_addr);
                    end else begin
                        mem_rdata = mem[mem_addr[15:2]];
                        rd_log.push_back(mem_addr);
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // lat = number of the cycle after the accepting edge in which cpu_done is seen (0 = timed out).
    task automatic access(input logic we, input logic [15:0] a, input logic [31:0] wd,
                          input int flush_at, output logic [31:0] rd, output int lat);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        @(posedge clk);
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            cpu_req   = 1'b0;
            cpu_flush = (i == flush_at);
            if (i == 1) check("busy_after_accept", cpu_busy, 1'b1);
            if (cpu_done) begin
                lat = i;
                rd  = cpu_rdata;
                check("busy_at_done", cpu_busy, 1'b0);
                break;
            end
        end
        cpu_flush = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          delay;
        int          flush_at;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    logic [31:0] rd;
    logic [15:0] base;
    int          lat, n_rd0, n_wr0, nreq0, n0;

    initial begin
        //            we    addr      wdata         dly flush rdata          lat nrd nwr
        vecs[0]  = '{1'b0, 16'h0424, 32'h0,         0,  0, 32'hA500_0424, 18, 8, 0};
        vecs[1]  = '{1'b0, 16'h0428, 32'h0,         0,  0, 32'hA500_0428,  3, 0, 0};
        vecs[2]  = '{1'b0, 16'h4424, 32'h0,         0,  0, 32'hA500_4424, 18, 8, 0};
        vecs[3]  = '{1'b0, 16'h0424, 32'h0,         0,  0, 32'hA500_0424, 18, 8, 0};
        vecs[4]  = '{1'b1, 16'h0430, 32'hDEADBEEF,  0,  0, 32'h0,          4, 0, 1};
        vecs[5]  = '{1'b0, 16'h0430, 32'h0,         0,  0, 32'hDEADBEEF,   3, 0, 0};
        vecs[6]  = '{1'b1, 16'h8000, 32'h12345678,  0,  0, 32'h0,          4, 0, 1};
        vecs[7]  = '{1'b0, 16'h8000, 32'h0,         0,  0, 32'h12345678,  18, 8, 0};
        vecs[8]  = '{1'b0, 16'h0434, 32'h0,         0,  0, 32'hA500_0434,  3, 0, 0};
        vecs[9]  = '{1'b0, 16'h003C, 32'h0,         0,  0, 32'hA500_003C, 18, 8, 0};
        vecs[10] = '{1'b0, 16'h0020, 32'h0,         0,  1, 32'hA500_0020,  3, 0, 0};
        vecs[11] = '{1'b0, 16'h8004, 32'h0,         0,  0, 32'hA500_8004,  3, 0, 0};
        vecs[12] = '{1'b0, 16'h0C24, 32'h0,         5,  0, 32'hA500_0C24, 58, 8, 0};

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", cpu_busy, 1'b0);
        check("rst_done", cpu_done, 1'b0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", cpu_busy, 1'b0);

        for (int k = 0; k < NV; k++) begin
            ack_delay = vecs[k].delay;
            n_rd0 = rd_log.size();
            n_wr0 = wr_log.size();
            nreq0 = req_cycles;
            access(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].flush_at, rd, lat);
            check($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
            check($sformatf("v%0d_mem_reads", k), rd_log.size() - n_rd0, vecs[k].exp_nrd);
            check($sformatf("v%0d_mem_writes", k), wr_log.size() - n_wr0, vecs[k].exp_nwr);
            if (!vecs[k].we) check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
            if (vecs[k].exp_nrd == 0 && vecs[k].exp_nwr == 0)
                check($sformatf("v%0d_no_mem_req", k), req_cycles - nreq0, 0);
            if (vecs[k].exp_nrd == 8 && rd_log.size() - n_rd0 == 8) begin
                base = vecs[k].addr & 16'hFFE0;
                for (int j = 0; j < 8; j++)
                    check($sformatf("v%0d_refill_addr%0d", k, j), rd_log[n_rd0 + j], base + 16'(4 * j));
            end
            if (vecs[k].exp_nwr == 1 && wr_log.size() - n_wr0 == 1) begin
                check($sformatf("v%0d_wr_addr", k), wr_log[n_wr0], vecs[k].addr & 16'hFFFC);
                check($sformatf("v%0d_wr_data", k), mem[vecs[k].addr[15:2]], vecs[k].wdata);
            end
        end

        // Flush and request in the same IDLE cycle: only the flush takes effect.
        ack_delay = 0;
        @(negedge clk);
        cpu_flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0C28;
        @(negedge clk);
        cpu_flush = 1'b0; cpu_req = 1'b0;
        check("flush_busy1", cpu_busy, 1'b0);
        @(negedge clk);
        check("flush_busy2", cpu_busy, 1'b0);
        check("flush_done", cpu_done, 1'b0);
        check("flush_mem_req", mem_req, 1'b0);
        n_rd0 = rd_log.size();
        access(1'b0, 16'h0C28, 32'h0, 0, rd, lat);
        check("after_flush_latency", lat, 18);
        check("after_flush_reads", rd_log.size() - n_rd0, 8);
        check("after_flush_rdata", rd, 32'hA500_0C28);

        // Slow memory, then reset while the fourth refill word is outstanding.
        ack_delay = 5;
        n0 = rd_log.size();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0824;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int i = 0; i < 300 && rd_log.size() < n0 + 3; i++) @(negedge clk);
        check("pre_rst_words", rd_log.size() - n0, 3);
        repeat (2) @(negedge clk);
        check("pre_rst_mem_req", mem_req, 1'b1);
        check("pre_rst_mem_addr", mem_addr, 16'h082C);
        check("pre_rst_busy", cpu_busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_mem_req", mem_req, 1'b0);
        check("mid_rst_mem_addr", mem_addr, 16'h0);
        check("mid_rst_busy", cpu_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check("mem_held_stable", stable_bad, 0);

        ack_delay = 0;
        n_rd0 = rd_log.size();
        access(1'b0, 16'h0824, 32'h0, 0, rd, lat);
        check("post_rst_miss_latency", lat, 18);
        check("post_rst_miss_reads", rd_log.size() - n_rd0, 8);
        check("post_rst_miss_rdata", rd, 32'hA500_0824);
        access(1'b0, 16'h0838, 32'h0, 0, rd, lat);
        check("post_rst_hit_latency", lat, 3);
        check("post_rst_hit_rdata", rd, 32'hA500_0838);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
